fetch_unit: RTL and testbench

- Instruction fetch / program-counter stage; sits directly upstream of the opcode decoder (ctrl) and consumes its jctrl/jrctrl outputs to select the next PC.
- Owns the 8-bit PC and the 8-bit instruction register (IR).
- Talks to instruction memory through a req/valid handshake.
- Presents opcode/immediate to the decoder for exactly the execute window, and produces the jal link address.

---
 rtl/fetch_unit_pkg.sv | 41 ++++
 rtl/fetch_unit_if.sv | 24 ++
 rtl/fetch_unit_next_pc_sel.sv | 50 +++++
 rtl/fetch_unit.sv | 84 ++++++++
 tb/tb_fetch_unit.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: widths, opcode map, state encoding
// and the immediate sign-extension helper used by the next-PC logic.
package fetch_unit_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 8;
  localparam int OPC_W   = 4;
  localparam int IMM_W   = 4;

  localparam logic [OPC_W-1:0] OPC_ADD  = 4'b0000;
  localparam logic [OPC_W-1:0] OPC_NAND = 4'b0010;
  localparam logic [OPC_W-1:0] OPC_SLT0 = 4'b0100;
  localparam logic [OPC_W-1:0] OPC_SLT1 = 4'b0101;
  localparam logic [OPC_W-1:0] OPC_SL   = 4'b0110;
  localparam logic [OPC_W-1:0] OPC_SR   = 4'b0111;
  localparam logic [OPC_W-1:0] OPC_LW   = 4'b1000;
  localparam logic [OPC_W-1:0] OPC_SW   = 4'b1001;
  localparam logic [OPC_W-1:0] OPC_ADDI = 4'b1010;
  localparam logic [OPC_W-1:0] OPC_JR   = 4'b1011;
  localparam logic [OPC_W-1:0] OPC_BEQ  = 4'b1100;
  localparam logic [OPC_W-1:0] OPC_JAL  = 4'b1110;
  localparam logic [OPC_W-1:0] OPC_HALT = 4'b1111;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_t;

  typedef enum logic [1:0] {
    SEL_SEQ = 2'd0,
    SEL_JR  = 2'd1,
    SEL_JAL = 2'd2,
    SEL_BEQ = 2'd3
  } npc_sel_t;

  function automatic logic signed [PC_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return signed'({{(PC_W-IMM_W){imm[IMM_W-1]}}, imm});
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port: fetch side issues req/addr, memory answers
// with valid/rdata in the same or a later cycle.
interface fetch_unit_if import fetch_unit_pkg::*; ();

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_valid;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_valid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_valid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_unit_next_pc_sel.sv
// Next-PC priority select (jr > jal > taken beq > sequential) with the
// branch-offset adder; purely combinational.
module next_pc_sel
  import fetch_unit_pkg::*;
(
  input  logic [PC_W-1:0]  pc,
  input  logic [OPC_W-1:0] opcode,
  input  logic [IMM_W-1:0] imm,
  input  logic             jctrl,
  input  logic             jrctrl,
  input  logic             alu_zero,
  input  logic [PC_W-1:0]  jr_target,
  output logic [PC_W-1:0]  next_pc,
  output logic [PC_W-1:0]  link_addr,
  output logic             link_sel
);

  logic signed [PC_W-1:0] offset;
  logic        [PC_W-1:0] seq_pc;
  logic        [PC_W-1:0] br_pc;
  npc_sel_t               sel;

  // All PC arithmetic wraps at 256; the signed offset is added in two's complement.
  assign offset    = sext_imm(imm);
  assign seq_pc    = pc + PC_W'(1);
  assign br_pc     = seq_pc + $unsigned(offset);
  assign link_addr = seq_pc;

  always_comb begin
    sel = SEL_SEQ;
    if (jrctrl)
      sel = SEL_JR;
    else if (jctrl && (opcode == OPC_JAL))
      sel = SEL_JAL;
    else if (jctrl && (opcode == OPC_BEQ) && alu_zero)
      sel = SEL_BEQ;
  end

  always_comb begin
    next_pc = seq_pc;
    unique case (sel)
      SEL_JR:           next_pc = jr_target;
      SEL_JAL, SEL_BEQ: next_pc = br_pc;
      default:          next_pc = seq_pc;
    endcase
  end

  assign link_sel = (sel == SEL_JAL);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch / PC stage: FETCH -> EXEC -> FETCH loop over a req/valid
// instruction port, with a terminal HALT state left only by reset.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [PC_W-1:0]  RESET_PC = 8'h00,
  parameter logic [OPC_W-1:0] HALT_OPC = 4'b1111
) (
  input  logic             clk,
  input  logic             rst_n,
  fetch_unit_if.master     imem,
  output logic [OPC_W-1:0] instr_opcode,
  output logic [IMM_W-1:0] instr_imm,
  output logic             instr_valid,
  input  logic             jctrl,
  input  logic             jrctrl,
  input  logic             alu_zero,
  input  logic [PC_W-1:0]  jr_target,
  input  logic             stall,
  output logic [PC_W-1:0]  pc,
  output logic [PC_W-1:0]  link_addr,
  output logic             link_we,
  output logic             halted
);

  fetch_state_t       state;
  logic [PC_W-1:0]    pc_q;
  logic [INSTR_W-1:0] ir_q;
  logic [PC_W-1:0]    next_pc;
  logic               link_sel;
  logic               exec_exit;

  next_pc_sel u_next_pc_sel (
    .pc        (pc_q),
    .opcode    (ir_q[INSTR_W-1 -: OPC_W]),
    .imm       (ir_q[IMM_W-1:0]),
    .jctrl     (jctrl),
    .jrctrl    (jrctrl),
    .alu_zero  (alu_zero),
    .jr_target (jr_target),
    .next_pc   (next_pc),
    .link_addr (link_addr),
    .link_sel  (link_sel)
  );

  assign exec_exit = (state == ST_EXEC) && !stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_FETCH;
      pc_q  <= RESET_PC;
      ir_q  <= '0;
    end else begin
      unique case (state)
        ST_FETCH: begin
          if (imem.imem_valid) begin
            ir_q  <= imem.imem_rdata;
            state <= (imem.imem_rdata[INSTR_W-1 -: OPC_W] == HALT_OPC) ? ST_HALT : ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (!stall) begin
            pc_q  <= next_pc;
            state <= ST_FETCH;
          end
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_FETCH;
      endcase
    end
  end

  // Request is masked while reset is asserted so the port is quiet during reset.
  assign imem.imem_req  = rst_n && (state == ST_FETCH);
  assign imem.imem_addr = pc_q;

  assign instr_opcode = ir_q[INSTR_W-1 -: OPC_W];
  assign instr_imm    = ir_q[IMM_W-1:0];
  assign instr_valid  = (state == ST_EXEC);
  assign halted       = (state == ST_HALT);
  assign pc           = pc_q;
  assign link_we      = exec_exit && link_sel;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural instruction memory with
// programmable latency, decoder controls driven directly.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            jctrl = 1'b0;
  logic            jrctrl = 1'b0;
  logic            alu_zero = 1'b0;
  logic [7:0]      jr_target = 8'h00;
  logic            stall = 1'b0;
  logic [3:0]      instr_opcode;
  logic [3:0]      instr_imm;
  logic            instr_valid;
  logic [7:0]      pc;
  logic [7:0]      link_addr;
  logic            link_we;
  logic            halted;

  logic [7:0]      mem [256];
  int              lat = 1;
  int              wcnt = 0;
  int              n_chk = 0;
  int              n_bad = 0;

  fetch_unit_if imem_bus ();

  fetch_unit #(.RESET_PC(8'h00), .HALT_OPC(4'b1111)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem         (imem_bus),
    .instr_opcode (instr_opcode),
    .instr_imm    (instr_imm),
    .instr_valid  (instr_valid),
    .jctrl        (jctrl),
    .jrctrl       (jrctrl),
    .alu_zero     (alu_zero),
    .jr_target    (jr_target),
    .stall        (stall),
    .pc           (pc),
    .link_addr    (link_addr),
    .link_we      (link_we),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  // Memory answers in the lat-th cycle of a held request.
  always @(posedge clk) begin
    if (imem_bus.imem_req && !imem_bus.imem_valid) wcnt <= wcnt + 1;
    else                                           wcnt <= 0;
  end
  assign imem_bus.imem_valid = imem_bus.imem_req && (wcnt >= lat - 1);
  assign imem_bus.imem_rdata = mem[imem_bus.imem_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic wait_exec();
    for (int i = 0; i < 20; i++) begin
      if (instr_valid) break;
      @(negedge clk);
    end
    chk("exec_wait", {31'd0, instr_valid}, 32'd1);
  endtask

  task automatic run_to(input logic [7:0] t);
    wait_exec();
    jrctrl    = 1'b1;
    jr_target = t;
    @(negedge clk);
    jrctrl    = 1'b0;
    chk("goto_pc", {24'd0, pc}, {24'd0, t});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h05] = 8'h37;
    mem[8'h10] = 8'hEE;
    mem[8'hFF] = 8'hC1;
    mem[8'h20] = 8'hB0;
    mem[8'h30] = 8'hF0;

    // reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst_pc",     {24'd0, pc}, 32'h00);
    chk("rst_req",    {31'd0, imem_bus.imem_req}, 32'd0);
    chk("rst_ivalid", {31'd0, instr_valid}, 32'd0);
    chk("rst_linkwe", {31'd0, link_we}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_ir",     {24'd0, instr_opcode, instr_imm}, 32'h00);

    // zero-wait sequential fetch: 2 cycles per instruction
    rst_n = 1'b1;
    #1;
    chk("seq_req0",  {31'd0, imem_bus.imem_req}, 32'd1);
    chk("seq_addr0", {24'd0, imem_bus.imem_addr}, 32'h00);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i % 2 == 1) begin
        chk("seq_ivalid", {31'd0, instr_valid}, 32'd1);
        chk("seq_noreq",  {31'd0, imem_bus.imem_req}, 32'd0);
      end else begin
        chk("seq_req",  {31'd0, imem_bus.imem_req}, 32'd1);
        chk("seq_addr", {24'd0, imem_bus.imem_addr}, i / 2);
        chk("seq_pc",   {24'd0, pc}, i / 2);
      end
    end

    // 3-cycle memory latency at 8'h05
    wait_exec();
    lat       = 3;
    jrctrl    = 1'b1;
    jr_target = 8'h05;
    @(negedge clk);
    jrctrl = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("lat_req",    {31'd0, imem_bus.imem_req}, 32'd1);
      chk("lat_addr",   {24'd0, imem_bus.imem_addr}, 32'h05);
      chk("lat_ivalid", {31'd0, instr_valid}, 32'd0);
      @(negedge clk);
    end
    chk("lat_exec",   {31'd0, instr_valid}, 32'd1);
    chk("lat_ir",     {24'd0, instr_opcode, instr_imm}, 32'h37);
    lat = 1;
    @(negedge clk);
    chk("lat_pc",     {24'd0, pc}, 32'h06);

    // jal at 8'h10, imm -2
    run_to(8'h10);
    wait_exec();
    jctrl = 1'b1;
    #1;
    chk("jal_link_addr", {24'd0, link_addr}, 32'h11);
    chk("jal_link_we",   {31'd0, link_we}, 32'd1);
    @(negedge clk);
    jctrl = 1'b0;
    chk("jal_pc",        {24'd0, pc}, 32'h0F);
    chk("jal_we_pulse",  {31'd0, link_we}, 32'd0);

    // beq at 8'hFF, taken then not taken
    run_to(8'hFF);
    wait_exec();
    jctrl    = 1'b1;
    alu_zero = 1'b1;
    #1;
    chk("beq_no_link", {31'd0, link_we}, 32'd0);
    @(negedge clk);
    jctrl    = 1'b0;
    alu_zero = 1'b0;
    chk("beq_taken_pc", {24'd0, pc}, 32'h01);
    run_to(8'hFF);
    wait_exec();
    jctrl = 1'b1;
    @(negedge clk);
    jctrl = 1'b0;
    chk("beq_nt_pc", {24'd0, pc}, 32'h00);

    // jr with jctrl also high, two stall cycles
    run_to(8'h20);
    wait_exec();
    stall     = 1'b1;
    jrctrl    = 1'b1;
    jctrl     = 1'b1;
    jr_target = 8'h42;
    #1;
    chk("jr_stall_we", {31'd0, link_we}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("jr_hold_pc",  {24'd0, pc}, 32'h20);
      chk("jr_hold_exe", {31'd0, instr_valid}, 32'd1);
      chk("jr_hold_ir",  {24'd0, instr_opcode, instr_imm}, 32'hB0);
    end
    stall = 1'b0;
    #1;
    chk("jr_exit_we", {31'd0, link_we}, 32'd0);
    @(negedge clk);
    jrctrl = 1'b0;
    jctrl  = 1'b0;
    chk("jr_pc", {24'd0, pc}, 32'h42);

    // halt, then asynchronous reset mid-HALT
    run_to(8'h30);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("halt_halted", {31'd0, halted}, 32'd1);
      chk("halt_req",    {31'd0, imem_bus.imem_req}, 32'd0);
      chk("halt_ivalid", {31'd0, instr_valid}, 32'd0);
      chk("halt_pc",     {24'd0, pc}, 32'h30);
      @(negedge clk);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pc",     {24'd0, pc}, 32'h00);
    chk("arst_halted", {31'd0, halted}, 32'd0);
    chk("arst_req",    {31'd0, imem_bus.imem_req}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_req",  {31'd0, imem_bus.imem_req}, 32'd1);
    chk("post_addr", {24'd0, imem_bus.imem_addr}, 32'h00);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
